// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM encoding and the rotating-priority pick helper
// for the 4-way round-robin MUX arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  typedef struct packed {
    logic             vld;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // First requester scanning upward from base+1, wrapping; base itself is checked last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                    input logic [SEL_W-1:0]   base);
    pick_t            p;
    logic [SEL_W-1:0] cand;
    p.vld = 1'b0;
    p.idx = base;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = base + SEL_W'(i);
      if (req[cand]) begin
        p.vld = 1'b1;
        p.idx = cand;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/MUX_4_1.sv
// 4:1 single-bit multiplexer with enable; output floats when disabled.
module MUX_4_1
  import mux_arb_pkg::*;
(
  input  logic             Enable_In,
  input  logic [SEL_W-1:0] Select_In,
  input  logic             Data_0_In,
  input  logic             Data_1_In,
  input  logic             Data_2_In,
  input  logic             Data_3_In,
  output wire              Data_Out
);

  logic sel_dat;

  always_comb begin
    sel_dat = Data_0_In;
    unique case (Select_In)
      2'd0: sel_dat = Data_0_In;
      2'd1: sel_dat = Data_1_In;
      2'd2: sel_dat = Data_2_In;
      2'd3: sel_dat = Data_3_In;
    endcase
  end

  assign Data_Out = Enable_In ? sel_dat : 1'bz;

endmodule

// File: rtl/mux_4_1_rr_arbiter.sv
// Round-robin arbiter owning a shared 4:1 MUX; grants last up to BURST_LEN cycles
// and re-arbitrate back-to-back on release. Grant/select/busy are registered.
module mux_4_1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int BURST_LEN = 4
) (
  input  logic               Clock_In,
  input  logic               Reset_n_In,
  input  logic [NUM_REQ-1:0] Request_In,
  input  logic [NUM_REQ-1:0] Data_In,
  output logic [NUM_REQ-1:0] Grant_Out,
  output logic [SEL_W-1:0]   Select_Out,
  output logic               Busy_Out,
  output wire                MUX_Data_Out
);

  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(BURST_LEN - 1);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [SEL_W-1:0]   last_q, last_d;

  logic [SEL_W-1:0]   base;
  pick_t              pick;
  logic               rel;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    hold_d  = hold_q;
    last_d  = last_q;

    // While granted, the current owner is the rotation point (it becomes Last_Owner on release).
    base = (state_q == GRANT) ? sel_q : last_q;
    pick = rr_pick(Request_In, base);
    rel  = (state_q == GRANT) && (!Request_In[sel_q] || (hold_q == HOLD_MAX));

    unique case (state_q)
      IDLE: begin
        if (pick.vld) begin
          state_d = GRANT;
          grant_d = NUM_REQ'(1) << pick.idx;
          sel_d   = pick.idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          last_d = sel_q;
          hold_d = '0;
          if (pick.vld) begin
            grant_d = NUM_REQ'(1) << pick.idx;
            sel_d   = pick.idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clock_In or negedge Reset_n_In) begin
    if (!Reset_n_In) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      hold_q  <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      hold_q  <= hold_d;
      last_q  <= last_d;
    end
  end

  assign Grant_Out  = grant_q;
  assign Select_Out = sel_q;
  assign Busy_Out   = busy_q;

  MUX_4_1 u_mux (
    .Enable_In (busy_q),
    .Select_In (sel_q),
    .Data_0_In (Data_In[0]),
    .Data_1_In (Data_In[1]),
    .Data_2_In (Data_In[2]),
    .Data_3_In (Data_In[3]),
    .Data_Out  (MUX_Data_Out)
  );

endmodule

// File: tb/tb_mux_4_1_rr_arbiter.sv
// Bench for mux_4_1_rr_arbiter: BURST_LEN=4 and BURST_LEN=1 instances against a
// behavioural owner/count/last-owner model.
module tb_mux_4_1_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req4 = '0, dat4 = '0, req1 = '0, dat1 = '0;
  logic [3:0] g4, g1;
  logic [1:0] s4, s1;
  logic       b4, b1;
  wire        m4, m1;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state per instance: owner index (-1 = nobody), cycles held, last released owner, select.
  int m_owner[2];
  int m_cnt[2];
  int m_last[2];
  int m_sel[2];
  int blen[2] = '{4, 1};

  mux_4_1_rr_arbiter #(.BURST_LEN(4)) u4 (
    .Clock_In(clk), .Reset_n_In(rst_n), .Request_In(req4), .Data_In(dat4),
    .Grant_Out(g4), .Select_Out(s4), .Busy_Out(b4), .MUX_Data_Out(m4)
  );

  mux_4_1_rr_arbiter #(.BURST_LEN(1)) u1 (
    .Clock_In(clk), .Reset_n_In(rst_n), .Request_In(req1), .Data_In(dat1),
    .Grant_Out(g1), .Select_Out(s1), .Busy_Out(b1), .MUX_Data_Out(m1)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] req, input int from);
    for (int k = 1; k <= 4; k++)
      if (req[(from + k) % 4]) return (from + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_owner[d] = -1;
      m_cnt[d]   = 0;
      m_last[d]  = 3;
      m_sel[d]   = 0;
    end
  endtask

  task automatic model_step(input int d, input logic [3:0] req);
    if (m_owner[d] < 0) begin
      if (req != 4'b0) begin
        m_owner[d] = pick(req, m_last[d]);
        m_sel[d]   = m_owner[d];
        m_cnt[d]   = 0;
      end
    end else if (!req[m_owner[d]] || m_cnt[d] == blen[d] - 1) begin
      m_last[d] = m_owner[d];
      m_cnt[d]  = 0;
      if (req != 4'b0) begin
        m_owner[d] = pick(req, m_last[d]);
        m_sel[d]   = m_owner[d];
      end else begin
        m_owner[d] = -1;
      end
    end else begin
      m_cnt[d]++;
    end
  endtask

  task automatic check_one(input int d, input string nm, input logic [3:0] g, input logic [1:0] s,
                           input logic b, input logic m, input logic [3:0] dat);
    logic [3:0] eg;
    logic [3:0] eb;
    eg = (m_owner[d] >= 0) ? (4'b0001 << m_owner[d]) : 4'b0000;
    eb = (m_owner[d] >= 0) ? 4'd1 : 4'd0;
    chk({nm, "_grant"}, g, eg);
    chk({nm, "_select"}, {2'b00, s}, 4'(m_sel[d]));
    chk({nm, "_busy"}, {3'b000, b}, eb);
    chk({nm, "_grant_onehot0"}, {3'b000, $onehot0(g)}, 4'd1);
    chk({nm, "_busy_vs_grant"}, {3'b000, b}, {3'b000, |g});
    if (m_owner[d] >= 0) begin
      chk({nm, "_mux_data"}, {3'b000, m}, {3'b000, dat[m_sel[d]]});
    end else if (dat[m_sel[d]]) begin
      n_cmp++;
      assert (m !== 1'b1)
      else begin
        n_bad++;
        $error("FAIL %s_mux_idle_driven observed=%b expected=z", nm, m);
      end
    end
  endtask

  task automatic check_all();
    check_one(0, "bl4", g4, s4, b4, m4, dat4);
    check_one(1, "bl1", g1, s1, b1, m1, dat1);
  endtask

  task automatic step();
    model_step(0, req4);
    model_step(1, req1);
    @(posedge clk);
    #1;
    check_all();
    dat4 = 4'($urandom);
    dat1 = 4'($urandom);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;

    // All four requesting: 0,1,2,3,0 in 4-cycle back-to-back bursts.
    req4 = 4'b1111;
    step();
    chk("r028_first_grant", g4, 4'b0001);
    repeat (19) step();
    chk("r028_fifth_grant", g4, 4'b0001);
    req4 = 4'b0000;
    repeat (3) step();

    // Single short request, then select must hold in idle.
    req4 = 4'b0100;
    repeat (2) step();
    req4 = 4'b0000;
    repeat (3) step();
    chk("r029_select_held", {2'b00, s4}, 4'd2);

    // Lone requester re-granted every burst without a gap.
    req4 = 4'b0010;
    repeat (10) step();
    req4 = 4'b0000;
    repeat (2) step();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) req4 = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req1 = 4'($urandom);
      step();
    end

    // Asynchronous reset in the middle of owner 2's burst.
    req4 = 4'b0000;
    req1 = 4'b0000;
    repeat (3) step();
    req4 = 4'b0100;
    repeat (2) step();
    chk("r031_pre_reset_grant", g4, 4'b0100);
    dat4 = 4'b1111;
    dat1 = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    req4 = 4'b1100;
    step();
    chk("r031_post_reset_grant", g4, 4'b0100);
    req4 = 4'b0000;
    repeat (2) step();

    // BURST_LEN=1: alternate 1,3 every cycle.
    req1 = 4'b1010;
    step();
    chk("r032_first", g1, 4'b0010);
    step();
    chk("r032_second", g1, 4'b1000);
    repeat (6) step();
    req1 = 4'b0000;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
